vector_mem_stage: RTL

Memory-stage sequencer that consumes the 8-lane vector result produced by the execute stage (`Out_v`) and serialises it into the 24-bit single-port data memory for vector stores. For vector loads, it reads 8 consecutive words back and assembles them into a lane vector for writeback. It sits between the EX/M pipeline register and data memory. It stalls the pipeline through `busy` while a vector transfer is in flight.

---
 rtl/vec_mem_pkg.sv | 19 +
 rtl/vec_lane_sel.sv | 17 +
 rtl/vector_mem_stage.sv | 134 +++++++++++++
 3 files changed

// File: rtl/vec_mem_pkg.sv
// Shared types for the vector memory stage: FSM states, lane vector and lane index width.
// No logic lives here.
package vec_mem_pkg;

    localparam int WIDTH_DEF        = 24;
    localparam int VECTOR_WIDTH_DEF = 8;
    localparam int LANE_IDX_W       = $clog2(VECTOR_WIDTH_DEF);

    typedef enum logic [2:0] {
        IDLE,
        STORE,
        LOAD,
        DRAIN,
        DONE
    } vmem_state_t;

    typedef logic [VECTOR_WIDTH_DEF-1:0][WIDTH_DEF-1:0] vec_t;

endpackage

// File: rtl/vec_lane_sel.sv
// Combinational lane multiplexer: picks lane[sel] out of a packed lane vector.
// Zero latency; no flow control.
module vec_lane_sel #(
    parameter int WIDTH        = 24,
    parameter int VECTOR_WIDTH = 8,
    parameter int IDX_W        = 3
) (
    input  logic [VECTOR_WIDTH-1:0][WIDTH-1:0] lanes,
    input  logic [IDX_W-1:0]                   sel,
    output logic [WIDTH-1:0]                   lane
);

    always_comb begin
        lane = lanes[sel];
    end

endmodule

// File: rtl/vector_mem_stage.sv
// Serialises vector stores / gathers vector loads over a single-port synchronous data memory.
// Store: 8 write cycles then DONE; load: 8 address cycles + 1 drain then DONE; busy stalls the pipe.
module vector_mem_stage #(
    parameter int WIDTH        = 24,
    parameter int VECTOR_WIDTH = 8
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                start,
    input  logic                                isStore,
    input  logic [WIDTH-1:0]                    baseAddr,
    input  logic [VECTOR_WIDTH-1:0][WIDTH-1:0]  storeData,
    output logic [WIDTH-1:0]                    memAddr,
    output logic                                memWE,
    output logic [WIDTH-1:0]                    memWD,
    input  logic [WIDTH-1:0]                    memRD,
    output logic [VECTOR_WIDTH-1:0][WIDTH-1:0]  loadData,
    output logic                                busy,
    output logic                                done
);

    import vec_mem_pkg::*;

    localparam int             IDX_W = (VECTOR_WIDTH > 1) ? $clog2(VECTOR_WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(VECTOR_WIDTH - 1);

    vmem_state_t                        state;
    vmem_state_t                        state_nxt;
    logic [IDX_W-1:0]                   idx;
    logic [WIDTH-1:0]                   base_q;
    logic [VECTOR_WIDTH-1:0][WIDTH-1:0] data_q;
    logic [VECTOR_WIDTH-1:0][WIDTH-1:0] load_q;
    logic [WIDTH-1:0]                   sel_lane;
    logic [WIDTH-1:0]                   lane_addr;

    vec_lane_sel #(
        .WIDTH        (WIDTH),
        .VECTOR_WIDTH (VECTOR_WIDTH),
        .IDX_W        (IDX_W)
    ) u_lane_sel (
        .lanes (data_q),
        .sel   (idx),
        .lane  (sel_lane)
    );

    // Wraps modulo 2^WIDTH by truncation.
    assign lane_addr = base_q + WIDTH'(idx);
    assign loadData  = load_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        memAddr   = '0;
        memWE     = 1'b0;
        memWD     = '0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE, DONE: begin
                done = (state == DONE);
                if (start) begin
                    state_nxt = isStore ? STORE : LOAD;
                end else begin
                    state_nxt = IDLE;
                end
            end
            STORE: begin
                busy    = 1'b1;
                memWE   = 1'b1;
                memAddr = lane_addr;
                memWD   = sel_lane;
                if (idx == LAST) begin
                    state_nxt = DONE;
                end
            end
            LOAD: begin
                busy    = 1'b1;
                memAddr = lane_addr;
                if (idx == LAST) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                busy      = 1'b1;
                state_nxt = DONE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Read data trails its address by one cycle, so lane idx-1 lands while idx is issued.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx    <= '0;
            base_q <= '0;
            data_q <= '0;
            load_q <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        idx    <= '0;
                        base_q <= baseAddr;
                        data_q <= storeData;
                    end
                end
                STORE: begin
                    idx <= idx + 1'b1;
                end
                LOAD: begin
                    if (idx != '0) begin
                        load_q[idx - 1'b1] <= memRD;
                    end
                    idx <= idx + 1'b1;
                end
                DRAIN: begin
                    load_q[VECTOR_WIDTH-1] <= memRD;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
